// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction queue between fetch and decode. Fetch pushes groups of one or
//   two instructions. Decode sees the two oldest entries and, when it signals
//   deq_ready, takes every entry that is presented.
//   Storage is a circular buffer with head (read) and tail (write) pointers.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   kill                synchronous flush (branch mispredict)
//   enq_valid           fetch group present
//   enq_inst1/2, enq_pc instructions of the group; enq_pc belongs to inst1
//   enq_invalid2        group holds only enq_inst1
//   enq_ready           room for a two-instruction group (DEPTH - count >= 2)
//   deq_ready           decode accepts every presented slot this cycle
//   deq_valid1/2        slot 1 (oldest) and slot 2 (second oldest) valid
//   deq_inst1/2         instructions in those slots, 0 when the slot is invalid
//   deq_pc1/2           PCs in those slots, 0 when the slot is invalid
//   count               number of occupied entries, 0..DEPTH
//
// Handshake: an enqueue fires on enq_valid && enq_ready. A dequeue fires on
// deq_ready and removes deq_valid1 + deq_valid2 entries. All outputs come
// from registered state only, so a newly written entry shows up on the
// following cycle at the earliest.
// -----------------------------------------------------------------------------
`ifndef INSN_LEN
`define INSN_LEN 32
`endif
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif

module fetch_queue #(
  parameter int DEPTH   = 8,
  parameter int PTR_LEN = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 kill,
  input  logic                 enq_valid,
  input  logic [`INSN_LEN-1:0] enq_inst1,
  input  logic [`INSN_LEN-1:0] enq_inst2,
  input  logic [`ADDR_LEN-1:0] enq_pc,
  input  logic                 enq_invalid2,
  output logic                 enq_ready,
  input  logic                 deq_ready,
  output logic                 deq_valid1,
  output logic                 deq_valid2,
  output logic [`INSN_LEN-1:0] deq_inst1,
  output logic [`INSN_LEN-1:0] deq_inst2,
  output logic [`ADDR_LEN-1:0] deq_pc1,
  output logic [`ADDR_LEN-1:0] deq_pc2,
  output logic [PTR_LEN:0]     count
);

  localparam logic [PTR_LEN:0] DEPTH_W  = (PTR_LEN+1)'(DEPTH);
  localparam logic [PTR_LEN:0] TWO_W    = (PTR_LEN+1)'(2);
  localparam logic [PTR_LEN-1:0] ONE_P  = PTR_LEN'(1);

  // Storage: not reset; entries outside head..tail are never presented.
  logic [`INSN_LEN-1:0] mem_inst_q [DEPTH];
  logic [`ADDR_LEN-1:0] mem_pc_q   [DEPTH];

  logic [PTR_LEN-1:0] head_q, head_d;
  logic [PTR_LEN-1:0] tail_q, tail_d;
  logic [PTR_LEN:0]   count_q, count_d;

  logic [PTR_LEN-1:0] head_p1;
  logic [PTR_LEN-1:0] tail_p1;
  logic               enq_fire;
  logic [PTR_LEN-1:0] nenq;   // 0..2, PTR_LEN >= 2 so it fits
  logic [PTR_LEN-1:0] ndeq;

  assign head_p1 = head_q + ONE_P;
  assign tail_p1 = tail_q + ONE_P;

  // Outputs depend only on registered state.
  assign enq_ready  = (count_q <= DEPTH_W - TWO_W);
  assign deq_valid1 = (count_q != '0);
  assign deq_valid2 = (count_q >= TWO_W);
  assign deq_inst1  = deq_valid1 ? mem_inst_q[head_q]  : '0;
  assign deq_pc1    = deq_valid1 ? mem_pc_q[head_q]    : '0;
  assign deq_inst2  = deq_valid2 ? mem_inst_q[head_p1] : '0;
  assign deq_pc2    = deq_valid2 ? mem_pc_q[head_p1]   : '0;
  assign count      = count_q;

  assign enq_fire = enq_valid && enq_ready;

  always_comb begin
    nenq = '0;
    if (enq_fire) nenq = enq_invalid2 ? PTR_LEN'(1) : PTR_LEN'(2);
  end

  always_comb begin
    ndeq = '0;
    if (deq_ready) ndeq = PTR_LEN'(deq_valid1) + PTR_LEN'(deq_valid2);
  end

  // Next-state: kill takes priority over any same-cycle enqueue/dequeue.
  always_comb begin
    head_d  = head_q + ndeq;
    tail_d  = tail_q + nenq;
    count_d = count_q + {1'b0, nenq} - {1'b0, ndeq};
    if (kill) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Second instruction of a pair lands at tail+1 with PC + 4.
  always_ff @(posedge clk) begin
    if (enq_fire && !kill) begin
      mem_inst_q[tail_q] <= enq_inst1;
      mem_pc_q[tail_q]   <= enq_pc;
      if (!enq_invalid2) begin
        mem_inst_q[tail_p1] <= enq_inst2;
        mem_pc_q[tail_p1]   <= enq_pc + `ADDR_LEN'(4);
      end
    end
  end

endmodule
